common_fifo_1w2r: RTL and testbench

Synchronous FIFO controller with one push port and a dual-entry pop window. It wraps a DFF-based storage array with one write port and two combinational read ports. Read port B always addresses the head entry and read port C the entry behind it, so a consumer (for example a dual-issue decode or commit stage) can inspect and retire up to two entries per cycle. The block owns the write and read pointers, occupancy count, flow control and flush; storage contents are plain data.

---
 rtl/common_fifo_1w2r_if.sv | 33 +++
 rtl/common_fifo_1w2r.sv | 77 +++++++
 tb/tb_common_fifo_1w2r.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/common_fifo_1w2r_if.sv
// Handshake bundle for common_fifo_1w2r.
//   flush      : synchronous clear of pointers and count
//   push_*     : single-entry producer port (valid/ready/data)
//   pop_req    : entries retired this cycle (0..2, 3 acts as 2)
//   pop0_*     : head entry window
//   pop1_*     : entry behind the head
//   count      : current occupancy, 0..DEPTH
// master = producer/consumer side, slave = the FIFO.
interface common_fifo_1w2r_if #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int FIFO_ADDR_WIDTH = 3
);
  logic                       flush;
  logic                       push_valid;
  logic                       push_ready;
  logic [FIFO_DATA_WIDTH-1:0] push_data;
  logic [1:0]                 pop_req;
  logic                       pop0_valid;
  logic [FIFO_DATA_WIDTH-1:0] pop0_data;
  logic                       pop1_valid;
  logic [FIFO_DATA_WIDTH-1:0] pop1_data;
  logic [FIFO_ADDR_WIDTH:0]   count;

  modport master (
    output flush, push_valid, push_data, pop_req,
    input  push_ready, pop0_valid, pop0_data, pop1_valid, pop1_data, count
  );

  modport slave (
    input  flush, push_valid, push_data, pop_req,
    output push_ready, pop0_valid, pop0_data, pop1_valid, pop1_data, count
  );
endinterface

// File: rtl/common_fifo_1w2r.sv
// common_fifo_1w2r: synchronous FIFO, one push port, two-entry pop window.
// DFF storage with one write port (wptr) and two combinational read ports:
// B at rptr (head) and C at rptr+1 (second entry). Up to two entries may be
// retired per cycle through pop_req.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : common_fifo_1w2r_if.slave (flush, push, pop window, count)
// Optional feature: define COMMON_FIFO_1W2R_BYPASS_EN to let a push into an
// empty FIFO appear on pop0 in the same cycle.
module common_fifo_1w2r #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int FIFO_ADDR_WIDTH = 3
) (
  input  logic                clk,
  input  logic                reset,
  common_fifo_1w2r_if.slave   bus
);
  localparam int DW    = FIFO_DATA_WIDTH;
  localparam int AW    = FIFO_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [AW-1:0]            wptr, rptr, rptr_p1;
  logic [AW:0]              count;
  logic                     push_acc, v0, v1;
  logic [1:0]               req_sat, nvalid, pop_eff;

  assign rptr_p1 = rptr + 1'b1;
  assign v1      = (count >= (AW+1)'(2));

  // Ready looks at registered occupancy only; a same-cycle pop never
  // frees a slot for a push.
  assign bus.push_ready = (count != DEPTH_C);
  assign push_acc       = bus.push_valid & bus.push_ready & ~bus.flush;

`ifdef COMMON_FIFO_1W2R_BYPASS_EN
  logic byp;
  // Empty FIFO: forward the incoming entry straight to the head window.
  // If it is popped, wptr and rptr both advance and count stays 0.
  assign byp           = (count == '0) & bus.push_valid & ~bus.flush;
  assign v0            = (count != '0) | byp;
  assign bus.pop0_data = byp ? bus.push_data : mem[rptr];
`else
  assign v0            = (count != '0);
  assign bus.pop0_data = mem[rptr];
`endif

  assign bus.pop0_valid = v0;
  assign bus.pop1_valid = v1;
  assign bus.pop1_data  = mem[rptr_p1];
  assign bus.count      = count;

  // Clamp the request to what is actually visible; excess is dropped.
  assign req_sat = (bus.pop_req == 2'd3) ? 2'd2 : bus.pop_req;
  assign nvalid  = {1'b0, v0} + {1'b0, v1};
  assign pop_eff = (req_sat < nvalid) ? req_sat : nvalid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (bus.flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_acc) mem[wptr] <= bus.push_data;
      wptr  <= wptr + AW'(push_acc);
      rptr  <= rptr + AW'(pop_eff);
      count <= count + (AW+1)'(push_acc) - (AW+1)'(pop_eff);
    end
  end
endmodule

// File: tb/tb_common_fifo_1w2r.sv
// Directed bench for common_fifo_1w2r (DEPTH=8, 32-bit entries).
module tb_common_fifo_1w2r;
  localparam int DW = 32;
  localparam int AW = 3;

  logic clk, reset;
  common_fifo_1w2r_if #(.FIFO_DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW)) bus ();

  common_fifo_1w2r #(.FIFO_DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          pv;
    logic [DW-1:0] pd;
    logic [1:0]    pr;
    logic          fl;
    logic          rdy, v0, v1;
    logic [DW-1:0] d0, d1;
    logic [AW:0]   cnt;
  } vec_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t tbl [21];

`ifdef COMMON_FIFO_1W2R_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic vec_t mk(logic pv, logic [DW-1:0] pd, logic [1:0] pr, logic fl,
                              logic rdy, logic v0, logic v1,
                              logic [DW-1:0] d0, logic [DW-1:0] d1, logic [AW:0] cnt);
    vec_t v;
    v.pv = pv; v.pd = pd; v.pr = pr; v.fl = fl;
    v.rdy = rdy; v.v0 = v0; v.v1 = v1; v.d0 = d0; v.d1 = d1; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs after the falling edge; outputs settle well before the next rising edge.
  task automatic drive(input logic pv, input logic [DW-1:0] pd, input logic [1:0] pr, input logic fl);
    @(negedge clk);
    bus.push_valid = pv;
    bus.push_data  = pd;
    bus.pop_req    = pr;
    bus.flush      = fl;
    #2;
  endtask

  initial begin
    // inputs: pv, pd, pr, fl | expected before the edge: rdy, v0, v1, d0, d1, count
    tbl[0]  = mk(0, 32'h0,  2'd0, 0, 1, 0, 0, 32'h0,  32'h0,  4'd0);
    tbl[1]  = mk(1, 32'hA1, 2'd0, 0, 1, 0, 0, 32'h0,  32'h0,  4'd0);
    tbl[2]  = mk(1, 32'hA2, 2'd0, 0, 1, 1, 0, 32'hA1, 32'h0,  4'd1);
    tbl[3]  = mk(1, 32'hA3, 2'd0, 0, 1, 1, 1, 32'hA1, 32'hA2, 4'd2);
    tbl[4]  = mk(0, 32'h0,  2'd2, 0, 1, 1, 1, 32'hA1, 32'hA2, 4'd3);
    tbl[5]  = mk(0, 32'h0,  2'd0, 0, 1, 1, 0, 32'hA3, 32'h0,  4'd1);
    tbl[6]  = mk(1, 32'hD1, 2'd0, 0, 1, 1, 0, 32'hA3, 32'h0,  4'd1);
    tbl[7]  = mk(1, 32'hD2, 2'd0, 0, 1, 1, 1, 32'hA3, 32'hD1, 4'd2);
    tbl[8]  = mk(1, 32'hD3, 2'd0, 0, 1, 1, 1, 32'hA3, 32'hD1, 4'd3);
    tbl[9]  = mk(1, 32'hD4, 2'd0, 0, 1, 1, 1, 32'hA3, 32'hD1, 4'd4);
    tbl[10] = mk(1, 32'hD5, 2'd0, 0, 1, 1, 1, 32'hA3, 32'hD1, 4'd5);
    tbl[11] = mk(1, 32'hD6, 2'd0, 0, 1, 1, 1, 32'hA3, 32'hD1, 4'd6);
    tbl[12] = mk(1, 32'hD7, 2'd0, 0, 1, 1, 1, 32'hA3, 32'hD1, 4'd7);
    // full: push refused while popping one
    tbl[13] = mk(1, 32'hE0, 2'd1, 0, 0, 1, 1, 32'hA3, 32'hD1, 4'd8);
    tbl[14] = mk(1, 32'hE0, 2'd0, 0, 1, 1, 1, 32'hD1, 32'hD2, 4'd7);
    tbl[15] = mk(0, 32'h0,  2'd0, 0, 0, 1, 1, 32'hD1, 32'hD2, 4'd8);
    // full: push refused, pop two
    tbl[16] = mk(1, 32'hF0, 2'd2, 0, 0, 1, 1, 32'hD1, 32'hD2, 4'd8);
    tbl[17] = mk(0, 32'h0,  2'd0, 0, 1, 1, 1, 32'hD3, 32'hD4, 4'd6);
    tbl[18] = mk(0, 32'h0,  2'd1, 0, 1, 1, 1, 32'hD3, 32'hD4, 4'd6);
    // flush at count 5 with push and pop_req=2
    tbl[19] = mk(1, 32'h99, 2'd2, 1, 1, 1, 1, 32'hD4, 32'hD5, 4'd5);
    // storage intact, pushed entry absent (index 0 still holds D6)
    tbl[20] = mk(0, 32'h0,  2'd3, 0, 1, 0, 0, 32'hD6, 32'hD7, 4'd0);

    bus.push_valid = 0; bus.push_data = '0; bus.pop_req = 0; bus.flush = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      logic          e_v0;
      logic [DW-1:0] e_d0;
      drive(tbl[i].pv, tbl[i].pd, tbl[i].pr, tbl[i].fl);
      e_v0 = tbl[i].v0;
      e_d0 = tbl[i].d0;
      if (BYP && tbl[i].cnt == 0 && tbl[i].pv && !tbl[i].fl) begin
        e_v0 = 1'b1;
        e_d0 = tbl[i].pd;
      end
      chk($sformatf("v%0d.push_ready", i), DW'(bus.push_ready), DW'(tbl[i].rdy));
      chk($sformatf("v%0d.pop0_valid", i), DW'(bus.pop0_valid), DW'(e_v0));
      chk($sformatf("v%0d.pop1_valid", i), DW'(bus.pop1_valid), DW'(tbl[i].v1));
      chk($sformatf("v%0d.pop0_data", i),  bus.pop0_data, e_d0);
      chk($sformatf("v%0d.pop1_data", i),  bus.pop1_data, tbl[i].d1);
      chk($sformatf("v%0d.count", i),      DW'(bus.count), DW'(tbl[i].cnt));
    end

    // Wrap-around: move rptr to 7 then place B7 at index 7 and B0 at index 0.
    for (int i = 0; i < 7; i++) drive(1, 32'h60 + DW'(i), 2'd0, 0);
    drive(0, 0, 2'd2, 0);
    drive(0, 0, 2'd2, 0);
    drive(0, 0, 2'd2, 0);
    drive(0, 0, 2'd1, 0);
    drive(1, 32'hB7, 2'd0, 0);
    drive(1, 32'hB0, 2'd0, 0);
    drive(0, 0, 2'd2, 0);
    chk("wrap.count_pre", DW'(bus.count), 32'd2);
    chk("wrap.pop0_data", bus.pop0_data, 32'hB7);
    chk("wrap.pop1_data", bus.pop1_data, 32'hB0);
    chk("wrap.pop1_valid", DW'(bus.pop1_valid), 32'd1);
    drive(0, 0, 2'd0, 0);
    chk("wrap.count_post", DW'(bus.count), 32'd0);
    // rptr=1: head window now shows storage indices 1 and 2
    chk("wrap.rptr_d0", bus.pop0_data, 32'h61);
    chk("wrap.rptr_d1", bus.pop1_data, 32'h62);

    // Empty FIFO, push 0xC5 with pop_req=1.
    drive(1, 32'hC5, 2'd1, 0);
    chk("byp.pop0_valid", DW'(bus.pop0_valid), DW'(BYP));
    if (BYP) chk("byp.pop0_data", bus.pop0_data, 32'hC5);
    drive(0, 0, 2'd0, 0);
    chk("byp.count", DW'(bus.count), BYP ? 32'd0 : 32'd1);

    // Reset asserted mid-cycle while a push is offered.
    drive(1, 32'hEE, 2'd0, 0);
    reset = 1'b1;
    #1;
    chk("rst.count_async", DW'(bus.count), 32'd0);
    @(negedge clk);
    bus.push_valid = 0;
    reset = 1'b0;
    #2;
    chk("rst.count", DW'(bus.count), 32'd0);
    chk("rst.push_ready", DW'(bus.push_ready), 32'd1);
    chk("rst.pop0_valid", DW'(bus.pop0_valid), 32'd0);
    chk("rst.pop0_data", bus.pop0_data, 32'h0);
    chk("rst.pop1_data", bus.pop1_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
